reset_value_monitor: RTL and testbench

Synthesizable, parametrised checker for reset values on monitored buses. On each rising edge of a monitored reset, every enabled channel must reach a reset value within a latency window. It must then hold that value until the monitored reset falls. Results are reported as pulses, sticky flags and saturating counters. The block sits beside a DUT in simulation or FPGA bring-up, and is the hardware counterpart of a property-style check of the form "reset rises implies data equals zero".

---
 rtl/reset_value_monitor_pkg.sv | 22 ++
 rtl/reset_value_monitor_ch.sv | 103 ++++++++++
 rtl/reset_value_monitor.sv | 142 ++++++++++++++
 tb/tb_reset_value_monitor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_value_monitor_pkg.sv
// Shared types and width helpers for the reset value monitor.
package reset_value_monitor_pkg;

   // Per-channel check state.
   typedef enum logic [1:0] {
      RVM_IDLE   = 2'd0,
      RVM_ARMED  = 2'd1,
      RVM_HOLD   = 2'd2,
      RVM_FAILED = 2'd3
   } rvm_state_e;

   // Width of the latency-window counter: $clog2(LATENCY+1), never below 1.
   function automatic int unsigned rvm_win_w(input int unsigned latency);
      return (latency < 1) ? 1 : $clog2(latency + 1);
   endfunction

   // Width of a channel index, never below 1.
   function automatic int unsigned rvm_idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reset_value_monitor_ch.sv
// One channel of the reset value monitor: check FSM plus latency-window counter.
// The pass/fail strobes are combinational; the top registers them together with
// the counters so that pulses and counts move in the same cycle.
module reset_value_monitor_ch
   import reset_value_monitor_pkg::*;
#(
   parameter int unsigned       WIDTH   = 16,
   parameter logic [WIDTH-1:0]  RST_VAL = '0,
   parameter int unsigned       LATENCY = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rise,
   input  logic             mon_rst,
   input  logic             en,
   input  logic [WIDTH-1:0] data,
   output logic             pass_stb,
   output logic             fail_stb
);

   localparam int unsigned WIN_W = rvm_win_w(LATENCY);
   typedef logic [WIN_W-1:0] win_t;
   localparam win_t WIN_LAST = win_t'(LATENCY);

   rvm_state_e state_q, state_d;
   win_t       win_q, win_d;
   logic       match;

   assign match = (data == RST_VAL);

   // Next-state and event decode. The rise cycle itself is the first sample of
   // the window, so IDLE evaluates it directly and the counter then holds the
   // number of samples already taken.
   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      pass_stb = 1'b0;
      fail_stb = 1'b0;
      if (!en) begin
         state_d = RVM_IDLE;
      end else begin
         case (state_q)
            RVM_IDLE: begin
               if (rise) begin
                  if (match) begin
                     state_d = RVM_HOLD;
                  end else if (LATENCY == 0) begin
                     fail_stb = 1'b1;
                     state_d  = RVM_FAILED;
                  end else begin
                     state_d = RVM_ARMED;
                     win_d   = win_t'(1);
                  end
               end
            end
            RVM_ARMED: begin
               if (!mon_rst) begin
                  // monitored reset was too short to reach the value
                  fail_stb = 1'b1;
                  state_d  = RVM_IDLE;
               end else if (match) begin
                  state_d = RVM_HOLD;
               end else if (win_q == WIN_LAST) begin
                  fail_stb = 1'b1;
                  state_d  = RVM_FAILED;
               end else begin
                  win_d = win_q + win_t'(1);
               end
            end
            RVM_HOLD: begin
               if (!mon_rst) begin
                  pass_stb = 1'b1;
                  state_d  = RVM_IDLE;
               end else if (!match) begin
                  fail_stb = 1'b1;
                  state_d  = RVM_FAILED;
               end
            end
            RVM_FAILED: begin
               // already reported; wait silently for the reset to drop
               if (!mon_rst) begin
                  state_d = RVM_IDLE;
               end
            end
            default: begin
               state_d = RVM_IDLE;
            end
         endcase
      end
   end

   // State and window counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RVM_IDLE;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
      end
   end

endmodule

// File: rtl/reset_value_monitor.sv
// Reset value monitor: checks that every enabled channel reaches RST_VAL within
// LATENCY cycles of a monitored-reset rise and holds it until the reset falls.
module reset_value_monitor
   import reset_value_monitor_pkg::*;
#(
   parameter int unsigned      NCH          = 4,
   parameter int unsigned      WIDTH        = 16,
   parameter logic [WIDTH-1:0] RST_VAL      = '0,
   parameter int unsigned      LATENCY      = 0,
   parameter int unsigned      CNT_W        = 16,
   parameter bit               STOP_ON_FAIL = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         mon_rst,
   input  logic [NCH*WIDTH-1:0]         data,
   input  logic [NCH-1:0]               chan_en,
   input  logic                         clr,
   output logic [NCH-1:0]               pass_pulse,
   output logic [NCH-1:0]               fail_pulse,
   output logic [NCH-1:0]               fail_sticky,
   output logic [CNT_W-1:0]             pass_cnt,
   output logic [CNT_W-1:0]             fail_cnt,
   output logic [rvm_idx_w(NCH)-1:0]    first_fail_ch,
   output logic                         first_fail_vld,
   output logic                         halt
);

   localparam int unsigned CH_W  = rvm_idx_w(NCH);
   localparam int unsigned PC_W  = $clog2(NCH + 1);
   localparam int unsigned SUM_W = CNT_W + PC_W;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

   logic             mon_rst_q;
   logic             rise;
   logic [NCH-1:0]   pass_ev, fail_ev;

   logic [NCH-1:0]   pass_pulse_q, pass_pulse_d;
   logic [NCH-1:0]   fail_pulse_q, fail_pulse_d;
   logic [NCH-1:0]   fail_sticky_q, fail_sticky_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic [CH_W-1:0]  ff_ch_q, ff_ch_d;
   logic             ff_vld_q, ff_vld_d;
   logic             halt_q, halt_d;

   logic [PC_W-1:0]  pass_pc, fail_pc;
   logic [SUM_W-1:0] pass_sum, fail_sum;
   logic [CH_W-1:0]  ff_lowest;

   // A reset already high when the block leaves reset counts as a rise.
   assign rise = mon_rst & ~mon_rst_q;

   // Per-channel checkers.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      reset_value_monitor_ch #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL),
         .LATENCY (LATENCY)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .rise     (rise),
         .mon_rst  (mon_rst),
         .en       (chan_en[i]),
         .data     (data[i*WIDTH +: WIDTH]),
         .pass_stb (pass_ev[i]),
         .fail_stb (fail_ev[i])
      );
   end

   // Population counts of this cycle's events and lowest failing channel.
   always_comb begin
      pass_pc   = '0;
      fail_pc   = '0;
      ff_lowest = '0;
      for (int i = 0; i < NCH; i++) begin
         pass_pc = pass_pc + PC_W'(pass_ev[i]);
         fail_pc = fail_pc + PC_W'(fail_ev[i]);
      end
      for (int i = NCH - 1; i >= 0; i--) begin
         if (fail_ev[i]) ff_lowest = CH_W'(i);
      end
   end

   // Next values of all reported state; clr wipes first, then events land.
   always_comb begin
      pass_pulse_d  = pass_ev;
      fail_pulse_d  = fail_ev;

      pass_sum   = SUM_W'(clr ? '0 : pass_cnt_q) + SUM_W'(pass_pc);
      fail_sum   = SUM_W'(clr ? '0 : fail_cnt_q) + SUM_W'(fail_pc);
      pass_cnt_d = (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
      fail_cnt_d = (fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];

      fail_sticky_d = (clr ? '0 : fail_sticky_q) | fail_ev;

      ff_vld_d = clr ? 1'b0 : ff_vld_q;
      ff_ch_d  = clr ? '0   : ff_ch_q;
      if (!ff_vld_d && (|fail_ev)) begin
         ff_vld_d = 1'b1;
         ff_ch_d  = ff_lowest;
      end

      halt_d = (clr ? 1'b0 : halt_q) | (STOP_ON_FAIL & (|fail_ev));
   end

   // Output and edge-detect registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mon_rst_q     <= 1'b0;
         pass_pulse_q  <= '0;
         fail_pulse_q  <= '0;
         fail_sticky_q <= '0;
         pass_cnt_q    <= '0;
         fail_cnt_q    <= '0;
         ff_ch_q       <= '0;
         ff_vld_q      <= 1'b0;
         halt_q        <= 1'b0;
      end else begin
         mon_rst_q     <= mon_rst;
         pass_pulse_q  <= pass_pulse_d;
         fail_pulse_q  <= fail_pulse_d;
         fail_sticky_q <= fail_sticky_d;
         pass_cnt_q    <= pass_cnt_d;
         fail_cnt_q    <= fail_cnt_d;
         ff_ch_q       <= ff_ch_d;
         ff_vld_q      <= ff_vld_d;
         halt_q        <= halt_d;
      end
   end

   assign pass_pulse     = pass_pulse_q;
   assign fail_pulse     = fail_pulse_q;
   assign fail_sticky    = fail_sticky_q;
   assign pass_cnt       = pass_cnt_q;
   assign fail_cnt       = fail_cnt_q;
   assign first_fail_ch  = ff_ch_q;
   assign first_fail_vld = ff_vld_q;
   assign halt           = halt_q;

endmodule

// File: tb/tb_reset_value_monitor.sv
// Bench for reset_value_monitor: each monitored-reset episode is scored by a
// model that derives each channel's outcome from the data seen while reset is high.
module tb_reset_value_monitor;

   localparam int NCH  = 4;
   localparam int W    = 16;
   localparam int LAT  = 2;
   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;
   localparam logic [W-1:0] RVAL = '0;

   logic              clk = 1'b0;
   logic              reset, mon_rst, clr;
   logic [NCH*W-1:0]  data;
   logic [NCH-1:0]    chan_en;
   logic [NCH-1:0]    pass_pulse, fail_pulse, fail_sticky;
   logic [CW-1:0]     pass_cnt, fail_cnt;
   logic [1:0]        first_fail_ch;
   logic              first_fail_vld, halt;

   reset_value_monitor #(
      .NCH(NCH), .WIDTH(W), .RST_VAL(RVAL), .LATENCY(LAT), .CNT_W(CW), .STOP_ON_FAIL(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .mon_rst(mon_rst), .data(data), .chan_en(chan_en), .clr(clr),
      .pass_pulse(pass_pulse), .fail_pulse(fail_pulse), .fail_sticky(fail_sticky),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_ch(first_fail_ch),
      .first_fail_vld(first_fail_vld), .halt(halt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference state
   int             m_pass, m_fail, m_ffc;
   logic [NCH-1:0] m_sticky;
   logic           m_ffv, m_halt;

   // episode description: data per channel per high cycle, enable drop cycle
   logic [W-1:0] ep_data [NCH][32];
   int           ep_off  [NCH];

   task automatic model_clear();
      m_pass = 0; m_fail = 0; m_ffc = 0; m_sticky = '0; m_ffv = 1'b0; m_halt = 1'b0;
   endtask

   task automatic ep_zero(input int h);
      for (int ch = 0; ch < NCH; ch++) begin
         ep_off[ch] = 99;
         for (int s = 0; s < 32; s++) ep_data[ch][s] = (s < h) ? RVAL : 16'hBEEF;
      end
   endtask

   // Drive one episode (h cycles high, g low) and score every cycle.
   task automatic run_episode(input int h, input int g, input int clr_at);
      logic [NCH-1:0] ep_p [0:40];
      logic [NCH-1:0] ep_f [0:40];
      int n;
      n = h + g;
      for (int i = 0; i <= 40; i++) begin ep_p[i] = '0; ep_f[i] = '0; end
      for (int ch = 0; ch < NCH; ch++) begin
         int first, dec;
         bit ok;
         first = -1;
         for (int s = 0; s < h && s <= LAT; s++)
            if (first < 0 && ep_data[ch][s] == RVAL) first = s;
         if (first < 0) begin
            ok  = 0;
            dec = (h <= LAT) ? h : LAT;   // too short, or window exhausted
         end else begin
            ok  = 1;
            dec = h;
            for (int s = first; s < h; s++)
               if (ok && ep_data[ch][s] != RVAL) begin ok = 0; dec = s; end
         end
         if (dec < ep_off[ch]) begin
            if (ok) ep_p[dec+1][ch] = 1'b1;
            else    ep_f[dec+1][ch] = 1'b1;
         end
      end
      for (int c = 0; c < n; c++) begin
         mon_rst = (c < h);
         clr     = (c == clr_at);
         for (int ch = 0; ch < NCH; ch++) begin
            data[ch*W +: W] = (c < h) ? ep_data[ch][c] : W'($urandom);
            chan_en[ch]     = (c < ep_off[ch]);
         end
         @(negedge clk);
         if (clr) model_clear();
         m_pass = m_pass + $countones(ep_p[c+1]);
         if (m_pass > CMAX) m_pass = CMAX;
         m_fail = m_fail + $countones(ep_f[c+1]);
         if (m_fail > CMAX) m_fail = CMAX;
         m_sticky = m_sticky | ep_f[c+1];
         if (!m_ffv && (|ep_f[c+1])) begin
            m_ffv = 1'b1;
            for (int ch = NCH - 1; ch >= 0; ch--) if (ep_f[c+1][ch]) m_ffc = ch;
         end
         if (|ep_f[c+1]) m_halt = 1'b1;

         checks += 8;
         if (pass_pulse !== ep_p[c+1]) begin errors++; $display("FAIL pass_pulse t=%0t: got %b want %b", $time, pass_pulse, ep_p[c+1]); end
         if (fail_pulse !== ep_f[c+1]) begin errors++; $display("FAIL fail_pulse t=%0t: got %b want %b", $time, fail_pulse, ep_f[c+1]); end
         if (pass_cnt !== CW'(m_pass)) begin errors++; $display("FAIL pass_cnt t=%0t: got %0d want %0d", $time, pass_cnt, m_pass); end
         if (fail_cnt !== CW'(m_fail)) begin errors++; $display("FAIL fail_cnt t=%0t: got %0d want %0d", $time, fail_cnt, m_fail); end
         if (fail_sticky !== m_sticky) begin errors++; $display("FAIL fail_sticky t=%0t: got %b want %b", $time, fail_sticky, m_sticky); end
         if (first_fail_vld !== m_ffv) begin errors++; $display("FAIL first_fail_vld t=%0t: got %b want %b", $time, first_fail_vld, m_ffv); end
         if (first_fail_ch !== 2'(m_ffc)) begin errors++; $display("FAIL first_fail_ch t=%0t: got %0d want %0d", $time, first_fail_ch, m_ffc); end
         if (halt !== m_halt) begin errors++; $display("FAIL halt t=%0t: got %b want %b", $time, halt, m_halt); end
      end
      clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; mon_rst = 1'b0; clr = 1'b0; data = '0; chan_en = '1;
      model_clear();
      @(negedge clk); @(negedge clk);
      checks++;
      if ({pass_pulse, fail_pulse, fail_sticky, pass_cnt, fail_cnt, first_fail_ch, first_fail_vld, halt} !== '0) begin
         errors++;
         $display("FAIL reset_state: got pp=%b fp=%b st=%b pc=%0d fc=%0d ff=%0d/%b h=%b want all 0",
                  pass_pulse, fail_pulse, fail_sticky, pass_cnt, fail_cnt, first_fail_ch, first_fail_vld, halt);
      end
      reset = 1'b0;
   endtask

   task automatic test_all_pass();
      ep_zero(5);
      run_episode(5, 2, -1);
      checks++;
      if (pass_cnt !== 3'd4) begin errors++; $display("FAIL all_pass_cnt: got %0d want 4", pass_cnt); end
   endtask

   task automatic test_latency();
      ep_zero(6);
      ep_data[1][0] = 16'h1234; ep_data[1][1] = 16'h0040;
      for (int s = 0; s < 6; s++) ep_data[2][s] = 16'h00A0 + 16'(s);
      run_episode(6, 2, -1);
      checks += 2;
      if (first_fail_ch !== 2'd2 || first_fail_vld !== 1'b1) begin
         errors++; $display("FAIL latency_first_fail: got %0d/%b want 2/1", first_fail_ch, first_fail_vld);
      end
      if (halt !== 1'b1) begin errors++; $display("FAIL latency_halt: got %b want 1", halt); end
   endtask

   task automatic test_hold_glitch();
      ep_zero(6);
      ep_data[0][3] = 16'h0001;
      run_episode(6, 2, 0);
      checks += 2;
      if (fail_cnt !== 3'd1 || pass_cnt !== 3'd3) begin
         errors++; $display("FAIL glitch_counts: got f=%0d p=%0d want f=1 p=3", fail_cnt, pass_cnt);
      end
      if (fail_sticky !== 4'b0001) begin errors++; $display("FAIL glitch_sticky: got %b want 0001", fail_sticky); end
   endtask

   task automatic test_short();
      ep_zero(1);
      ep_data[0][0] = 16'h0F0F;
      run_episode(1, 3, 0);
      checks++;
      if (fail_cnt !== 3'd1) begin errors++; $display("FAIL short_fail_cnt: got %0d want 1", fail_cnt); end
   endtask

   task automatic test_chan_en();
      ep_zero(5);
      ep_off[2] = 3; ep_off[3] = 0;
      ep_data[3][1] = 16'h7777;
      run_episode(5, 2, 0);
      checks++;
      if (pass_cnt !== 3'd2 || fail_cnt !== 3'd0) begin
         errors++; $display("FAIL chan_en_counts: got p=%0d f=%0d want p=2 f=0", pass_cnt, fail_cnt);
      end
   endtask

   task automatic test_saturate_clr();
      ep_zero(2);
      ep_off[1] = 0; ep_off[2] = 0; ep_off[3] = 0;
      run_episode(2, 1, 0);
      for (int k = 0; k < 8; k++) run_episode(2, 1, -1);
      checks++;
      if (pass_cnt !== 3'd7) begin errors++; $display("FAIL saturate_pass_cnt: got %0d want 7", pass_cnt); end
      ep_zero(4);
      ep_off[1] = 0; ep_off[2] = 0; ep_off[3] = 0;
      for (int s = 0; s < 4; s++) ep_data[0][s] = 16'h8000;
      run_episode(4, 2, LAT);    // clr lands on the window-miss sample
      checks++;
      if (fail_cnt !== 3'd1 || pass_cnt !== 3'd0) begin
         errors++; $display("FAIL clr_with_fail: got f=%0d p=%0d want f=1 p=0", fail_cnt, pass_cnt);
      end
   endtask

   task automatic test_random();
      for (int e = 0; e < 40; e++) begin
         int h, g, m, gl, ca;
         h = $urandom_range(1, 8);
         g = $urandom_range(1, 3);
         for (int ch = 0; ch < NCH; ch++) begin
            m  = $urandom_range(0, LAT + 1);
            gl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, h - 1) : -1;
            for (int s = 0; s < 32; s++)
               ep_data[ch][s] = (s < m || s == gl) ? W'($urandom_range(1, 65535)) : RVAL;
            ep_off[ch] = ($urandom_range(0, 5) == 0) ? $urandom_range(0, h) : 99;
         end
         ca = ($urandom_range(0, 7) == 0) ? $urandom_range(0, h + g - 1) : -1;
         run_episode(h, g, ca);
      end
   endtask

   task automatic test_async_reset();
      mon_rst = 1'b1; data = '0; chan_en = '1; clr = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (pass_pulse !== '0 || fail_pulse !== '0) begin
            errors++; $display("FAIL async_hold_pulses: got p=%b f=%b want 0/0", pass_pulse, fail_pulse);
         end
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({pass_pulse, fail_pulse, fail_sticky, pass_cnt, fail_cnt, first_fail_ch, first_fail_vld, halt} !== '0) begin
         errors++;
         $display("FAIL async_reset_outputs: got pp=%b fp=%b st=%b pc=%0d fc=%0d ff=%0d/%b h=%b want all 0",
                  pass_pulse, fail_pulse, fail_sticky, pass_cnt, fail_cnt, first_fail_ch, first_fail_vld, halt);
      end
      model_clear();
      @(negedge clk); @(negedge clk);
      reset = 1'b0;               // monitored reset still high: re-armed on first edge
      ep_zero(3);
      run_episode(3, 2, -1);
      checks++;
      if (pass_cnt !== 3'd4) begin errors++; $display("FAIL async_rearm_pass_cnt: got %0d want 4", pass_cnt); end
   endtask

   initial begin
      test_reset();
      test_all_pass();
      test_latency();
      test_hold_glitch();
      test_short();
      test_chan_en();
      test_saturate_clr();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
